// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the multiplexed 7-segment display controller:
//   - GLYPH_TAB : 16-entry active-low segment table, bit order g..a
//   - SEG_BLANK : all segments off
//   - cnt_w()   : counter width helper, never narrower than 1 bit
//   - DEF_*     : default parameter values for the top level
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low glyphs, index = nibble value, bits = {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_TAB [0:15] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    localparam int DEF_NUM_DIGITS      = 4;
    localparam int DEF_DISPLAY_REFRESH = 27000;
    localparam int DEF_DUTY_W          = 3;
    localparam int DEF_BLINK_FRAMES    = 64;

    // Width of a counter that must hold values 0..n-1
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_glyph_dec.sv
// ---------------------------------------------------------------------------
// seg7_glyph_dec
// Nibble to active-low 7-segment pattern.
// Ports:
//   i_nib      : 4-bit digit value
//   i_hex_mode : 1 = show 10..15 as A..F, 0 = blank them
//   i_blank    : force all segments off
//   o_seg      : segments g..a, active-low
// ---------------------------------------------------------------------------
module seg7_glyph_dec
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_hex_mode,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = GLYPH_TAB[i_nib];
        if (i_blank || (!i_hex_mode && (i_nib > 4'd9))) begin
            o_seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg7_mux_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_mux_ctrl
// Time-multiplexed common-anode 7-segment controller with frame-synchronous
// input capture, leading-zero blanking, per-digit dp/blink and PWM dimming.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   bcd_i        : digit nibbles, digit k = bcd_i[4k+3:4k], digit 0 rightmost
//   dp_i         : per-digit decimal point enable
//   blink_i      : per-digit blink enable
//   hex_mode_i   : 1 = hex glyphs, 0 = decimal (10..15 blanked)
//   blank_lz_i   : suppress leading zeros
//   bright_i     : on-time (bright_i+1)/2**DUTY_W of each digit slot
//   anodo_o      : digit enables, active-low, at most one low
//   catodo_o     : segments g..a, active-low
//   dp_o         : decimal point segment, active-low
//   frame_o      : one-cycle pulse when the digit index wraps to 0
// ---------------------------------------------------------------------------
module seg7_mux_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS      = DEF_NUM_DIGITS,
    parameter int DISPLAY_REFRESH = DEF_DISPLAY_REFRESH,
    parameter int DUTY_W          = DEF_DUTY_W,
    parameter int BLINK_FRAMES    = DEF_BLINK_FRAMES
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] bcd_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blink_i,
    input  logic                    hex_mode_i,
    input  logic                    blank_lz_i,
    input  logic [DUTY_W-1:0]       bright_i,
    output logic [NUM_DIGITS-1:0]   anodo_o,
    output logic [6:0]              catodo_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int SLOT_W = cnt_w(DISPLAY_REFRESH);
    localparam int IDX_W  = cnt_w(NUM_DIGITS);
    localparam int BLK_W  = cnt_w(BLINK_FRAMES);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DISPLAY_REFRESH - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

    logic [SLOT_W-1:0]       r_slot_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [DUTY_W-1:0]       r_pwm;
    logic [BLK_W-1:0]        r_blk_cnt;
    logic                    r_blk_on;

    logic [4*NUM_DIGITS-1:0] r_snap_bcd;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic [NUM_DIGITS-1:0]   r_snap_blink;
    logic                    r_snap_hex;
    logic                    r_snap_lz;
    logic [DUTY_W-1:0]       r_snap_bright;

    logic                    w_slot_end;
    logic                    w_wrap;
    logic [3:0]              w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic                    w_significant;
    logic                    w_blink_off;
    logic                    w_pwm_on;
    logic [6:0]              w_seg;

    assign w_slot_end = (r_slot_cnt == '0);
    assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);

    // Slot / digit / pwm / blink counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_slot_cnt <= SLOT_LAST;
            r_idx      <= '0;
            r_pwm      <= '0;
            r_blk_cnt  <= '0;
            r_blk_on   <= 1'b1;
        end else begin
            if (w_slot_end) begin
                r_slot_cnt <= SLOT_LAST;
                r_pwm      <= '0;
                r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_slot_cnt <= r_slot_cnt - SLOT_W'(1);
                r_pwm      <= r_pwm + DUTY_W'(1);
            end
            if (w_wrap) begin
                if (r_blk_cnt == BLK_LAST) begin
                    r_blk_cnt <= '0;
                    r_blk_on  <= ~r_blk_on;
                end else begin
                    r_blk_cnt <= r_blk_cnt + BLK_W'(1);
                end
            end
        end
    end

    // Inputs are only sampled on the frame wrap so a frame never tears
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_snap_bcd    <= '0;
            r_snap_dp     <= '0;
            r_snap_blink  <= '0;
            r_snap_hex    <= 1'b0;
            r_snap_lz     <= 1'b0;
            r_snap_bright <= '0;
        end else if (w_wrap) begin
            r_snap_bcd    <= bcd_i;
            r_snap_dp     <= dp_i;
            r_snap_blink  <= blink_i;
            r_snap_hex    <= hex_mode_i;
            r_snap_lz     <= blank_lz_i;
            r_snap_bright <= bright_i;
        end
    end

    // Scan from the most significant digit down: once a nonzero nibble or a
    // set dp is seen, that digit and every lower one stay visible.
    always_comb begin
        w_lz_blank    = '0;
        w_significant = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_nib[k] = r_snap_bcd[4*k +: 4];
        end
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_significant = w_significant || (w_nib[k] != 4'd0) || r_snap_dp[k];
            w_lz_blank[k] = r_snap_lz && (k != 0) && !w_significant;
        end
    end

    assign w_blink_off = r_snap_blink[r_idx] && !r_blk_on;
    assign w_pwm_on    = (r_pwm <= r_snap_bright);

    seg7_glyph_dec u_glyph (
        .i_nib      (w_nib[r_idx]),
        .i_hex_mode (r_snap_hex),
        .i_blank    (w_lz_blank[r_idx] || w_blink_off),
        .o_seg      (w_seg)
    );

    // Registered outputs, one clock behind the index/pwm state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            anodo_o  <= '1;
            catodo_o <= SEG_BLANK;
            dp_o     <= 1'b1;
            frame_o  <= 1'b0;
        end else begin
            anodo_o  <= w_pwm_on ? ~(NUM_DIGITS'(1) << r_idx) : '1;
            catodo_o <= w_seg;
            dp_o     <= ~(r_snap_dp[r_idx] && !w_blink_off);
            frame_o  <= w_wrap;
        end
    end

endmodule

// File: tb/tb_seg7_mux_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_mux_ctrl
// Two instances share one stimulus stream: a 4-digit build (8-clock slots,
// blink every 2 frames) and a 3-digit build (16-clock slots, blink every
// frame). A time-based reference model predicts each output cycle; the
// prediction is queued when the inputs for that cycle are driven and is
// popped when the registered output appears one clock later.
// ---------------------------------------------------------------------------
module tb_seg7_mux_ctrl;

    localparam int ND1 = 4, DR1 = 8,  BF1 = 2;
    localparam int ND2 = 3, DR2 = 16, BF2 = 1;
    localparam int TOTAL = 760;
    localparam int RST_N = 575;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic [3:0]  blink;
        logic        hex;
        logic        lz;
        logic [2:0]  bright;
    } snap_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] cat;
        logic       dp;
        logic       frame;
    } obs_t;

    localparam obs_t RST_OBS1 = '{an: 4'hF, cat: 7'h7F, dp: 1'b1, frame: 1'b0};
    localparam obs_t RST_OBS2 = '{an: 4'h7, cat: 7'h7F, dp: 1'b1, frame: 1'b0};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd;
    logic [3:0]  dp_en;
    logic [3:0]  blink;
    logic        hex;
    logic        lz;
    logic [2:0]  bright;

    logic [3:0]  an1;
    logic [6:0]  cat1;
    logic        dp1;
    logic        fr1;
    logic [2:0]  an2;
    logic [6:0]  cat2;
    logic        dp2;
    logic        fr2;

    obs_t q1[$];
    obs_t q2[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seg7_mux_ctrl #(
        .NUM_DIGITS(ND1), .DISPLAY_REFRESH(DR1), .DUTY_W(3), .BLINK_FRAMES(BF1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .bcd_i(bcd), .dp_i(dp_en), .blink_i(blink),
        .hex_mode_i(hex), .blank_lz_i(lz), .bright_i(bright),
        .anodo_o(an1), .catodo_o(cat1), .dp_o(dp1), .frame_o(fr1)
    );

    seg7_mux_ctrl #(
        .NUM_DIGITS(ND2), .DISPLAY_REFRESH(DR2), .DUTY_W(3), .BLINK_FRAMES(BF2)
    ) dut2 (
        .clk_i(clk), .rst_i(rst), .bcd_i(bcd[11:0]), .dp_i(dp_en[2:0]),
        .blink_i(blink[2:0]), .hex_mode_i(hex), .blank_lz_i(lz), .bright_i(bright),
        .anodo_o(an2), .catodo_o(cat2), .dp_o(dp2), .frame_o(fr2)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Expected output produced from the state held c clocks after reset
    function automatic obs_t model(input int nd, input int dr, input int bf,
                                   input int c, input snap_t s);
        obs_t       o;
        int         idx, pwm, f, msd;
        logic [3:0] nib;
        logic       boff, lzb;
        idx = (c / dr) % nd;
        pwm = (c % dr) % 8;
        f   = c / (dr * nd);
        msd = 0;
        for (int k = 0; k < nd; k++)
            if ((s.bcd[4*k +: 4] != 4'd0) || s.dp[k]) msd = k;
        nib  = s.bcd[4*idx +: 4];
        boff = s.blink[idx] && (((f / bf) % 2) == 1);
        lzb  = s.lz && (idx > msd);
        o.an = 4'h0;
        for (int k = 0; k < nd; k++)
            o.an[k] = !((k == idx) && (pwm <= int'(s.bright)));
        o.cat   = (lzb || boff || (!s.hex && nib > 4'd9)) ? 7'h7F : glyph(nib);
        o.dp    = !(s.dp[idx] && !boff);
        o.frame = (((c + 1) % (dr * nd)) == 0);
        return o;
    endfunction

    task automatic drive(input int n);
        rst = (n == RST_N);
        if (n < 70) begin
            bcd = 16'h1234; bright = 3'd7; hex = 1'b0; lz = 1'b0; dp_en = 4'h0; blink = 4'h0;
        end else if (n < 150) begin
            bcd = 16'h00A5; hex = 1'b1; lz = 1'b1;
        end else if (n < 230) begin
            hex = 1'b0;
        end else if (n < 300) begin
            bcd = 16'h0005; dp_en = 4'b0100; hex = 1'b1;
        end else if (n < 380) begin
            bcd = 16'h1234; bright = 3'd1; dp_en = 4'h0; lz = 1'b0;
        end else if (n < 540) begin
            bcd = 16'h8F90; bright = 3'd7; blink = 4'b0001;
        end else if (n < 556) begin
            bcd = 16'h1111; blink = 4'h0;
        end else if (n < 600) begin
            bcd = 16'h2222;
        end else if ((n % 7) == 0) begin
            bcd    = 16'($urandom);
            dp_en  = 4'($urandom);
            blink  = 4'($urandom);
            hex    = 1'($urandom);
            lz     = 1'($urandom);
            bright = 3'($urandom);
        end
    endtask

    initial begin
        snap_t s1, s2, cur;
        obs_t  e1, e2;
        int    c;
        rst = 1'b1;
        bcd = '0; dp_en = '0; blink = '0; hex = 1'b0; lz = 1'b0; bright = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        s1 = '0;
        s2 = '0;
        c  = 0;
        q1.push_back(RST_OBS1);
        q2.push_back(RST_OBS2);
        for (int n = 0; n < TOTAL; n++) begin
            e1 = q1.pop_front();
            e2 = q2.pop_front();
            check_eq($sformatf("d4.an@%0d", n),    32'(an1),  32'(e1.an));
            check_eq($sformatf("d4.seg@%0d", n),   32'(cat1), 32'(e1.cat));
            check_eq($sformatf("d4.dp@%0d", n),    32'(dp1),  32'(e1.dp));
            check_eq($sformatf("d4.frame@%0d", n), 32'(fr1),  32'(e1.frame));
            check_eq($sformatf("d3.an@%0d", n),    32'(an2),  32'(e2.an));
            check_eq($sformatf("d3.seg@%0d", n),   32'(cat2), 32'(e2.cat));
            check_eq($sformatf("d3.dp@%0d", n),    32'(dp2),  32'(e2.dp));
            check_eq($sformatf("d3.frame@%0d", n), 32'(fr2),  32'(e2.frame));

            drive(n);
            cur = '{bcd: bcd, dp: dp_en, blink: blink, hex: hex, lz: lz, bright: bright};
            if (rst) begin
                q1.push_back(RST_OBS1);
                q2.push_back(RST_OBS2);
                s1 = '0;
                s2 = '0;
                c  = 0;
            end else begin
                q1.push_back(model(ND1, DR1, BF1, c, s1));
                q2.push_back(model(ND2, DR2, BF2, c, s2));
                if (((c + 1) % (DR1 * ND1)) == 0) s1 = cur;
                if (((c + 1) % (DR2 * ND2)) == 0) s2 = cur;
                c++;
            end
            @(negedge clk);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
